// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_pkg
// Purpose  : Beat-width default and beat-count width helper for the simple_* stages.
// Revision : 1.0 - initial release
// ============================================================================
package simple_pkg;

  // Beat width of the xor/and stage output that the packer consumes.
  localparam int BEAT_W = 2;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_2_pack.sv
`default_nettype none
// ============================================================================
// Module   : simple_2_pack
// Purpose  : Packs N consecutive W-bit beats into one N*W-bit word, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module simple_2_pack
  import simple_pkg::*;
#(
  parameter int  W  = BEAT_W,
  parameter int  N  = 4,
  localparam int CW = cnt_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic [CW-1:0]  out_beats,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int            c_word_w  = N * W;
  localparam logic [CW-1:0] c_n_beats = CW'(N);

  logic [c_word_w-1:0] r_buf;
  logic [CW-1:0]       r_cnt;
  logic                r_full;
  logic                r_last;

  logic          w_acc;
  logic          w_drn;
  logic [CW-1:0] w_cnt_nxt;

  // A held word may drain and admit a new beat in the same cycle.
  assign in_ready  = !r_full || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_drn     = r_full && out_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_last <= 1'b0;
    end else if (!r_full) begin
      if (w_acc) begin
        r_buf[int'(r_cnt)*W +: W] <= in_data;
        r_cnt                     <= w_cnt_nxt;
        if ((w_cnt_nxt == c_n_beats) || in_last) begin
          r_full <= 1'b1;
          r_last <= in_last;
        end
      end
    end else if (w_drn) begin
      if (w_acc) begin
        // Overwrite the whole word so earlier slots read back as zero padding.
        r_buf  <= c_word_w'(in_data);
        r_cnt  <= CW'(1);
        r_full <= (N == 1) || in_last;
        r_last <= in_last;
      end else begin
        r_buf  <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  assign out_data  = r_buf;
  assign out_beats = r_cnt;
  assign out_valid = r_full;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_simple_2_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_2_pack
// Purpose  : Directed vector table plus randomized traffic against a beat-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_2_pack;
  import simple_pkg::*;

  localparam int W  = BEAT_W;
  localparam int N  = 4;
  localparam int CW = cnt_width(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [CW-1:0]  out_beats;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  simple_2_pack #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           vld;
    logic [W-1:0]   d;
    logic           lst;
    logic           ordy;
    logic           chk_ir;
    logic           ir;
    logic           ov;
    logic [N*W-1:0] od;
    logic [CW-1:0]  ob;
    logic           ol;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input int d, input logic l,
                              input logic ordy, input logic chk_ir, input logic ir,
                              input logic ov, input int od, input int ob, input logic ol);
    vec_t e;
    e.rst = r; e.vld = v; e.d = W'(d); e.lst = l; e.ordy = ordy;
    e.chk_ir = chk_ir; e.ir = ir;
    e.ov = ov; e.od = (N*W)'(od); e.ob = CW'(ob); e.ol = ol;
    vecs.push_back(e);
  endfunction

  task automatic chk_out(input string name, input logic ov, input logic [N*W-1:0] od,
                         input logic [CW-1:0] ob, input logic ol);
    total++;
    if (out_valid !== ov || out_data !== od || out_beats !== ob || out_last !== ol) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%h beats=%0d last=%b, want valid=%b data=%h beats=%0d last=%b",
               name, out_valid, out_data, out_beats, out_last, ov, od, ob, ol);
    end
  endtask

  task automatic chk_ir(input string name, input logic exp);
    total++;
    if (in_ready !== exp) begin
      bad++;
      $display("FAIL %s: in_ready got %b want %b", name, in_ready, exp);
    end
  endtask

  // Model state: beats of the word being filled, plus at most one finished word.
  logic [W-1:0]   cur_q[$];
  bit             pend;
  logic [N*W-1:0] pend_data;
  int             pend_beats;
  bit             pend_last;

  function automatic logic [N*W-1:0] pack_q();
    logic [N*W-1:0] w = '0;
    for (int k = 0; k < cur_q.size(); k++) w[k*W +: W] = cur_q[k];
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    //   rst v  d  l  ordy chk ir  ov od    ob ol
    // Reset, then idle
    add(1, 0, 0, 0, 0, 0, 0,  0, 'h00, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 'h00, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);
    // 1,2,3,0 -> 0x39, valid for one cycle
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h01, 1, 0);
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h09, 2, 0);
    add(0, 1, 3, 0, 1, 1, 1,  0, 'h39, 3, 0);
    add(0, 1, 0, 0, 1, 1, 1,  1, 'h39, 4, 0);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);
    // Hold 0x39 under backpressure, then drain while accepting 3
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h01, 1, 0);
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h09, 2, 0);
    add(0, 1, 3, 0, 1, 1, 1,  0, 'h39, 3, 0);
    add(0, 1, 0, 0, 0, 1, 1,  1, 'h39, 4, 0);
    add(0, 1, 3, 0, 0, 1, 0,  1, 'h39, 4, 0);
    add(0, 1, 3, 0, 0, 1, 0,  1, 'h39, 4, 0);
    add(0, 1, 3, 0, 0, 1, 0,  1, 'h39, 4, 0);
    add(0, 1, 3, 0, 1, 1, 1,  0, 'h03, 1, 0);
    add(0, 1, 0, 1, 1, 1, 1,  1, 'h03, 2, 1);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);
    // 2, then 1 with last -> 0x06; next word starts clean
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h02, 1, 0);
    add(0, 1, 1, 1, 1, 1, 1,  1, 'h06, 2, 1);
    add(0, 1, 3, 0, 1, 1, 1,  0, 'h03, 1, 0);
    add(0, 1, 0, 1, 1, 1, 1,  1, 'h03, 2, 1);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);
    // Eight continuous beats -> 0xE4 twice, four cycles apart
    add(0, 1, 0, 0, 1, 1, 1,  0, 'h00, 1, 0);
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h04, 2, 0);
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h24, 3, 0);
    add(0, 1, 3, 0, 1, 1, 1,  1, 'hE4, 4, 0);
    add(0, 1, 0, 0, 1, 1, 1,  0, 'h00, 1, 0);
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h04, 2, 0);
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h24, 3, 0);
    add(0, 1, 3, 0, 1, 1, 1,  1, 'hE4, 4, 0);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);
    // Partial word, reset with a beat offered, then 1,1,1,1 -> 0x55
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h01, 1, 0);
    add(0, 1, 2, 0, 1, 1, 1,  0, 'h09, 2, 0);
    add(1, 1, 3, 0, 1, 0, 0,  0, 'h00, 0, 0);
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h01, 1, 0);
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h05, 2, 0);
    add(0, 1, 1, 0, 1, 1, 1,  0, 'h15, 3, 0);
    add(0, 1, 1, 0, 1, 1, 1,  1, 'h55, 4, 0);
    add(0, 0, 0, 0, 1, 1, 1,  0, 'h00, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].d;
      in_last = vecs[i].lst; out_ready = vecs[i].ordy;
      #1;
      if (vecs[i].chk_ir) chk_ir($sformatf("vec%0d_ir", i), vecs[i].ir);
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ob, vecs[i].ol);
    end

    // Randomized traffic from the empty state left by the table.
    cur_q.delete();
    pend = 0; pend_data = '0; pend_beats = 0; pend_last = 0;
    for (int c = 0; c < 400; c++) begin
      logic exp_ir, acc;
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ir = !pend || out_ready;
      chk_ir($sformatf("rnd%0d_ir", c), exp_ir);
      acc = in_valid && exp_ir;
      if (pend && out_ready) pend = 0;
      if (acc) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == N || in_last) begin
          pend       = 1;
          pend_data  = pack_q();
          pend_beats = cur_q.size();
          pend_last  = in_last;
          cur_q.delete();
        end
      end
      @(posedge clk);
      #1;
      if (pend)
        chk_out($sformatf("rnd%0d_word", c), 1'b1, pend_data, CW'(pend_beats), pend_last);
      else
        chk_out($sformatf("rnd%0d_fill", c), 1'b0, pack_q(), CW'(cur_q.size()), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
